// File: rtl/seq_pattern_detector_pkg.sv
// Shared constants for the serial pattern detector: FSM encoding and the default
// pattern, also used by the bench's reference model.
package seq_det_pkg;

  localparam int unsigned         DEF_PAT_LEN = 4;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1011;

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  // Width of a counter that must reach n inclusive.
  function automatic int unsigned fill_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Bus between the serial front-end (master) and the pattern detector (slave).
// The par_out/par_valid pair exists only when SEQ_DET_PAR_OUT_EN is defined.
interface seq_pattern_detector_if
  import seq_det_pkg::*;
#(
  parameter int unsigned CNT_W = 8
`ifdef SEQ_DET_PAR_OUT_EN
  , parameter int unsigned PAT_LEN = DEF_PAT_LEN
`endif
) ();

  logic             clr;
  logic             bit_valid;
  logic             bit_in;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
`ifdef SEQ_DET_PAR_OUT_EN
  logic [PAT_LEN-1:0] par_out;
  logic               par_valid;

  modport master (output clr, bit_valid, bit_in,
                  input  match, match_cnt, par_out, par_valid);
  modport slave  (input  clr, bit_valid, bit_in,
                  output match, match_cnt, par_out, par_valid);
`else
  modport master (output clr, bit_valid, bit_in,
                  input  match, match_cnt);
  modport slave  (input  clr, bit_valid, bit_in,
                  output match, match_cnt);
`endif

endinterface

// File: rtl/seq_pattern_detector_sipo_shift.sv
// Serial-in shift register with enable and synchronous clear; exposes the value it
// will load so callers can compare against the post-shift word in the same cycle.
module sipo_shift #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         bit_i,
  output logic [W-1:0] nxt_o
);

  logic [W-1:0] sr_q;

  assign nxt_o = {sr_q[W-2:0], bit_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (clr_i) begin
      sr_q <= '0;
    end else if (en_i) begin
      sr_q <= nxt_o;
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Parametrised serial bit-pattern detector with saturating match counter.
// Define SEQ_DET_PAR_OUT_EN to add the par_out/par_valid deserialiser output.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned        PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
  parameter bit                 OVERLAP = 1'b1,
  parameter int unsigned        CNT_W   = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  seq_pattern_detector_if.slave bus
);

  localparam int unsigned      FW       = fill_w(PAT_LEN);
  localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_LEN);
  localparam logic [FW-1:0]    FILL_ARM = FW'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic               accept;
  logic               hit;
  logic [PAT_LEN-1:0] hist_nxt;
  logic [FW-1:0]      fill_q, fill_d;
  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               match_q;

  // clr wins over a simultaneous valid bit, which is then dropped.
  assign accept = bus.bit_valid & ~bus.clr;

  sipo_shift #(.W(PAT_LEN)) u_hist (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (bus.clr),
    .en_i  (accept),
    .bit_i (bus.bit_in),
    .nxt_o (hist_nxt)
  );

  // The completing bit may arrive while still one short of a full window.
  assign hit = accept && ((state_q == ST_ARMED) || (fill_q == FILL_ARM))
               && (hist_nxt == PATTERN);

  always_comb begin
    fill_d = fill_q;
    if (bus.clr) begin
      fill_d = '0;
    end else if (accept) begin
      if (hit && !OVERLAP) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FW'(1);
      end
    end
    state_d = (fill_d == FILL_MAX) ? ST_ARMED : ST_FILL;

    cnt_d = cnt_q;
    if (bus.clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q  <= '0;
      state_q <= ST_FILL;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      fill_q  <= fill_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      match_q <= hit;
    end
  end

  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;

`ifdef SEQ_DET_PAR_OUT_EN
  localparam int unsigned   PW       = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam logic [PW-1:0] PAR_LAST = PW'(PAT_LEN - 1);

  logic [PW-1:0]      par_cnt_q;
  logic [PAT_LEN-1:0] par_out_q;
  logic               par_valid_q;

  // Grouping counts every accepted bit, regardless of matches or OVERLAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_cnt_q   <= '0;
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
    end else if (bus.clr) begin
      par_cnt_q   <= '0;
      par_valid_q <= 1'b0;
    end else if (accept) begin
      par_valid_q <= (par_cnt_q == PAR_LAST);
      if (par_cnt_q == PAR_LAST) begin
        par_cnt_q <= '0;
        par_out_q <= hist_nxt;
      end else begin
        par_cnt_q <= par_cnt_q + PW'(1);
      end
    end else begin
      par_valid_q <= 1'b0;
    end
  end

  assign bus.par_out   = par_out_q;
  assign bus.par_valid = par_valid_q;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: three instances (overlap, non-overlap, 2-bit counter)
// share one stimulus stream and are checked each cycle against a queued reference model.
`timescale 1ns/1ps
module tb_seq_pattern_detector;
  import seq_det_pkg::*;

  localparam int unsigned   PL  = DEF_PAT_LEN;
  localparam logic [PL-1:0] PAT = DEF_PATTERN;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_r, vld_r, bit_r;

  always #5 clk = ~clk;

  seq_pattern_detector_if #(.CNT_W(8)) bus0 ();
  seq_pattern_detector_if #(.CNT_W(8)) bus1 ();
  seq_pattern_detector_if #(.CNT_W(2)) bus2 ();

  assign bus0.clr = clr_r;  assign bus0.bit_valid = vld_r;  assign bus0.bit_in = bit_r;
  assign bus1.clr = clr_r;  assign bus1.bit_valid = vld_r;  assign bus1.bit_in = bit_r;
  assign bus2.clr = clr_r;  assign bus2.bit_valid = vld_r;  assign bus2.bit_in = bit_r;

  seq_pattern_detector #(.PAT_LEN(PL), .PATTERN(PAT), .OVERLAP(1'b1), .CNT_W(8)) u_dut_ov (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  seq_pattern_detector #(.PAT_LEN(PL), .PATTERN(PAT), .OVERLAP(1'b0), .CNT_W(8)) u_dut_nov (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  seq_pattern_detector #(.PAT_LEN(PL), .PATTERN(PAT), .OVERLAP(1'b1), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  logic [2:0] act_m;
  logic [7:0] act_cnt [3];
  assign act_m      = {bus2.match, bus1.match, bus0.match};
  assign act_cnt[0] = bus0.match_cnt;
  assign act_cnt[1] = bus1.match_cnt;
  assign act_cnt[2] = {6'b0, bus2.match_cnt};

  int n_checks = 0;
  int n_fail   = 0;
  int pulses [3];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: bits since restart and the raw bit history.
  typedef struct packed {
    logic [1:0] idx;
    logic       m;
    logic [7:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0]   m_hist;
  int            m_run [3];
  int            m_cnt [3];
  int            m_pcnt;
  logic [PL-1:0] m_pout;
  logic          m_pv;

  function automatic int cnt_max(input int i);
    return (i == 2) ? 3 : 255;
  endfunction

  function automatic bit overlaps(input int i);
    return (i != 1);
  endfunction

  task automatic model_reset();
    m_hist = '0;
    m_pcnt = 0;
    m_pout = '0;
    m_pv   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_run[i] = 0;
      m_cnt[i] = 0;
    end
  endtask

  task automatic clear_pulses();
    for (int i = 0; i < 3; i++) pulses[i] = 0;
  endtask

  task automatic cycle(input logic v, input logic b, input logic c);
    exp_t e;
    bit   h;
    vld_r = v;
    bit_r = b;
    clr_r = c;
    if (c) begin
      m_hist = '0;
      m_pcnt = 0;
      m_pv   = 1'b0;
    end else if (v) begin
      m_hist = {m_hist[30:0], b};
      m_pv   = 1'b0;
      m_pcnt++;
      if (m_pcnt == PL) begin
        m_pout = m_hist[PL-1:0];
        m_pv   = 1'b1;
        m_pcnt = 0;
      end
    end else begin
      m_pv = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      h = 1'b0;
      if (c) begin
        m_run[i] = 0;
        m_cnt[i] = 0;
      end else if (v) begin
        m_run[i]++;
        h = (m_run[i] >= PL) && (m_hist[PL-1:0] == PAT);
        if (h) begin
          if (m_cnt[i] < cnt_max(i)) m_cnt[i]++;
          if (!overlaps(i)) m_run[i] = 0;
        end
      end
      e.idx = 2'(i);
      e.m   = h;
      e.cnt = 8'(m_cnt[i]);
      exp_q.push_back(e);
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (exp_q.size() == 0) begin
        check_eq("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq($sformatf("match%0d", e.idx), {31'b0, act_m[e.idx]}, {31'b0, e.m});
        check_eq($sformatf("cnt%0d", e.idx), {24'b0, act_cnt[e.idx]}, {24'b0, e.cnt});
      end
      pulses[i] += int'(act_m[i]);
    end
`ifdef SEQ_DET_PAR_OUT_EN
    check_eq("par_valid", {31'b0, bus0.par_valid}, {31'b0, m_pv});
    check_eq("par_out", {28'b0, bus0.par_out}, {28'b0, m_pout});
`endif
  endtask

  task automatic rst_pulse();
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  s10;
    logic [3:0]  s4;
    logic [7:0]  s8;
    rst_n = 1'b0;
    clr_r = 1'b0;
    vld_r = 1'b0;
    bit_r = 1'b0;
    model_reset();
    clear_pulses();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst_match%0d", i), {31'b0, act_m[i]}, 32'd0);
      check_eq($sformatf("rst_cnt%0d", i), {24'b0, act_cnt[i]}, 32'd0);
    end
`ifdef SEQ_DET_PAR_OUT_EN
    check_eq("rst_par_out", {28'b0, bus0.par_out}, 32'd0);
    check_eq("rst_par_valid", {31'b0, bus0.par_valid}, 32'd0);
`endif
    rst_n = 1'b1;

    // Overlap vs non-overlap on 1011011011
    s10 = 10'b1011011011;
    for (int j = 9; j >= 0; j--) cycle(1'b1, s10[j], 1'b0);
    check_eq("ov_cnt", {24'b0, act_cnt[0]}, 32'd3);
    check_eq("nov_cnt", {24'b0, act_cnt[1]}, 32'd2);
    check_eq("ov_pulses", pulses[0], 32'd3);
    check_eq("nov_pulses", pulses[1], 32'd2);

    // Mid-stream asynchronous reset discards the partial 101
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    rst_pulse();
    check_eq("midrst_cnt", {24'b0, act_cnt[0]}, 32'd0);
    check_eq("midrst_match", {31'b0, act_m[0]}, 32'd0);
    cycle(1'b1, 1'b1, 1'b0);
    check_eq("midrst_nomatch", {31'b0, act_m[0]}, 32'd0);
    s4 = 4'b1011;
    for (int j = 3; j >= 0; j--) cycle(1'b1, s4[j], 1'b0);
    check_eq("midrst_hit", {31'b0, act_m[0]}, 32'd1);
    check_eq("midrst_cnt1", {24'b0, act_cnt[0]}, 32'd1);

    // Gaps of idle cycles between bits
    cycle(1'b0, 1'b0, 1'b1);
    clear_pulses();
    for (int j = 3; j >= 0; j--) begin
      cycle(1'b1, s4[j], 1'b0);
      if (j != 0) repeat (5) cycle(1'b0, 1'b1, 1'b0);
    end
    check_eq("gap_hit", {31'b0, act_m[0]}, 32'd1);
    cycle(1'b0, 1'b0, 1'b0);
    check_eq("gap_pulses", pulses[0], 32'd1);

    // Saturation and clr colliding with a completing bit
    cycle(1'b0, 1'b0, 1'b1);
    repeat (5) for (int j = 3; j >= 0; j--) cycle(1'b1, s4[j], 1'b0);
    check_eq("sat_cnt", {24'b0, act_cnt[2]}, 32'd3);
    check_eq("unsat_cnt", {24'b0, act_cnt[0]}, 32'd5);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    check_eq("clr_nomatch", {31'b0, act_m[0]}, 32'd0);
    check_eq("clr_cnt_sat", {24'b0, act_cnt[2]}, 32'd0);
    check_eq("clr_cnt", {24'b0, act_cnt[0]}, 32'd0);

    // Deserialiser grouping on 1100_1011
    s8 = 8'b1100_1011;
    for (int j = 7; j >= 0; j--) begin
      cycle(1'b1, s8[j], 1'b0);
`ifdef SEQ_DET_PAR_OUT_EN
      if (j == 4) begin
        check_eq("par_word0", {28'b0, bus0.par_out}, 32'hC);
        check_eq("par_strobe0", {31'b0, bus0.par_valid}, 32'd1);
      end
      if (j == 0) begin
        check_eq("par_word1", {28'b0, bus0.par_out}, 32'hB);
        check_eq("par_strobe1", {31'b0, bus0.par_valid}, 32'd1);
      end
`endif
    end
    check_eq("par_match", {31'b0, act_m[0]}, 32'd1);

    // Randomised traffic with occasional clr
    for (int k = 0; k < 10000; k++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
